// File: rtl/pipe_pkg.sv
// Shared definitions for the two-entry skid pipeline register:
// the occupancy state encoding and the default data width.
package pipe_pkg;

    localparam int PIPE_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// WIDTH-bit storage register with load enable and synchronous active-high
// clear to zero; used for both the main and the skid entry.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_r;

    // Entry storage: clear on reset, capture d when load is asserted.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            data_r <= {WIDTH{1'b0}};
        end else if (load) begin
            data_r <= d;
        end else begin
            data_r <= data_r;
        end
    end

    assign q = data_r;

endmodule

// File: rtl/pipe_skid_reg32.sv
// Two-entry valid/ready skid register with fully registered handshake outputs.
// Define PIPE_SKID_FLUSH_EN to add the synchronous Flush input.
module pipe_skid_reg32
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] In_D,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Out_D,
    output logic             Out_Valid,
    input  logic             Out_Ready
`ifdef PIPE_SKID_FLUSH_EN
    ,
    input  logic             Flush
`endif
);

    pipe_state_e      state_r;
    pipe_state_e      state_nx_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             drain_s;
    logic             main_load_s;
    logic             skid_load_s;
    logic [WIDTH-1:0] main_d_s;
    logic [WIDTH-1:0] main_q_s;
    logic [WIDTH-1:0] skid_q_s;

    // Handshakes use only registered flags, so Out_Ready never reaches In_Ready.
    assign accept_s = In_Valid & in_ready_r;
    assign drain_s  = out_valid_r & Out_Ready;

    // Next-state and entry-load decode.
    always_comb begin
        state_nx_s  = state_r;
        main_load_s = 1'b0;
        skid_load_s = 1'b0;
        main_d_s    = In_D;
`ifdef PIPE_SKID_FLUSH_EN
        if (Flush) begin
            state_nx_s = EMPTY;
        end else begin
`endif
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_nx_s  = ONE;
                    main_load_s = 1'b1;
                end else begin
                    state_nx_s = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && !drain_s) begin
                    state_nx_s  = FULL;
                    skid_load_s = 1'b1;
                end else if (drain_s && !accept_s) begin
                    state_nx_s = EMPTY;
                end else if (accept_s && drain_s) begin
                    state_nx_s  = ONE;
                    main_load_s = 1'b1;
                end else begin
                    state_nx_s = ONE;
                end
            end
            FULL: begin
                if (drain_s) begin
                    state_nx_s  = ONE;
                    main_load_s = 1'b1;
                    main_d_s    = skid_q_s;
                end else begin
                    state_nx_s = FULL;
                end
            end
            default: begin
                state_nx_s = EMPTY;
            end
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        end
`endif
    end

    // State register with handshake flags pre-decoded from the next state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s != FULL);
            out_valid_r <= (state_nx_s != EMPTY);
        end
    end

    pipe_entry_reg #(.WIDTH(WIDTH)) u_main (
        .Clk  (Clk),
        .Rst  (Rst),
        .load (main_load_s),
        .d    (main_d_s),
        .q    (main_q_s)
    );

    pipe_entry_reg #(.WIDTH(WIDTH)) u_skid (
        .Clk  (Clk),
        .Rst  (Rst),
        .load (skid_load_s),
        .d    (In_D),
        .q    (skid_q_s)
    );

    assign In_Ready  = in_ready_r;
    assign Out_Valid = out_valid_r;
    assign Out_D     = main_q_s;

endmodule

// File: tb/tb_pipe_skid_reg32.sv
// Directed and random checks of pipe_skid_reg32 against an occupancy model
// and an in-order word queue. Flush cases build with PIPE_SKID_FLUSH_EN.
module tb_pipe_skid_reg32;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] In_D;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] Out_D;
    logic        Out_Valid;
    logic        Out_Ready;
`ifdef PIPE_SKID_FLUSH_EN
    logic        Flush;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          cnt = 0;
    logic [31:0] q[$];

    pipe_skid_reg32 #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_D      (In_D),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Out_D     (Out_D),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready)
`ifdef PIPE_SKID_FLUSH_EN
        ,
        .Flush     (Flush)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Check outputs held since the last edge, drive inputs, update the model, advance one cycle.
    task automatic step(input logic v, input logic [31:0] d, input logic r,
                        input logic rst, input logic fl);
        logic acc;
        logic drn;
        In_Valid  = v;
        In_D      = d;
        Out_Ready = r;
        Rst       = rst;
`ifdef PIPE_SKID_FLUSH_EN
        Flush     = fl;
`endif
        vectors++;
        chk("in_ready", {31'd0, In_Ready}, {31'd0, (cnt != 2)});
        chk("out_valid", {31'd0, Out_Valid}, {31'd0, (cnt != 0)});
        if (cnt != 0) chk("out_d", Out_D, q[0]);
        acc = v && (cnt != 2);
        drn = (cnt != 0) && r;
        if (rst || fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        cnt = q.size();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        In_Valid  = 1'b0;
        In_D      = 32'd0;
        Out_Ready = 1'b0;
        Rst       = 1'b1;
`ifdef PIPE_SKID_FLUSH_EN
        Flush     = 1'b0;
`endif
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("reset_out_d", Out_D, 32'd0);

        // single word, one-cycle latency
        step(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        chk("lat_out_valid", {31'd0, Out_Valid}, 32'd1);
        chk("lat_out_d", Out_D, 32'h1234_5678);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // backpressure fills both entries, 0xC waits upstream
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", {31'd0, In_Ready}, 32'd0);
        step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        chk("refill_in_ready", {31'd0, In_Ready}, 32'd1);
        step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // streaming at one word per cycle
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // reset while full discards both words
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        chk("rst_out_d", Out_D, 32'd0);
        chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
        step(1'b1, 32'h88, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

`ifdef PIPE_SKID_FLUSH_EN
        // flush while full: 0xD ignored, main entry keeps 0xA
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b1, 1'b0, 1'b1);
        chk("flush_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("flush_out_d", Out_D, 32'hA);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hE, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
`endif

        // random valid/ready traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("final_empty", {31'd0, Out_Valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg32.md
PIPE_SKID_REG32 -- requirements
Module: pipe_skid_reg32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width in bits.
REQ-002 SHALL have port Clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port In_D  input  WIDTH  upstream data.
REQ-005 SHALL have port In_Valid  input  1  upstream offers In_D this cycle.
REQ-006 SHALL have port In_Ready  output  1  block accepts In_D this cycle.
REQ-007 SHALL have port Out_D  output  WIDTH  downstream data, registered.
REQ-008 SHALL have port Out_Valid  output  1  Out_D holds a valid word.
REQ-009 SHALL have port Out_Ready  input  1  downstream consumes Out_D this cycle.
REQ-010 SHALL have port Flush  input  1  synchronous discard of all held words; present only under PIPE_SKID_FLUSH_EN.

Function
REQ-011 SHALL define accept = In_Valid & In_Ready and drain = Out_Valid & Out_Ready.
REQ-012 SHALL hold two WIDTH-bit entries: main, driven on Out_D, and skid.
REQ-013 SHALL implement states EMPTY, ONE and FULL.
REQ-014 SHALL drive In_Ready = (state != FULL) and Out_Valid = (state != EMPTY), both decoded from registered state only, with no combinational path from Out_Ready.
REQ-015 SHALL transition from EMPTY on accept to ONE with main <= In_D, and otherwise stay in EMPTY.
REQ-016 SHALL, in ONE: on accept & !drain, go to FULL with skid <= In_D; on drain & !accept, go to EMPTY; on accept & drain, stay in ONE with main <= In_D; otherwise hold.
REQ-017 SHALL, in FULL: on drain, go to ONE with main <= skid; otherwise hold. Accept is impossible in FULL.
REQ-018 SHALL have a latency of 1 cycle from accept to the word appearing on Out_D with Out_Valid=1 when the block was EMPTY.
REQ-019 SHALL deliver words in acceptance order, with no loss or duplication.
REQ-020 SHALL keep Out_D stable while Out_Valid=1 and Out_Ready=0.
REQ-021 SHALL sustain full throughput of one word per cycle when Out_Ready is held at 1.
REQ-022 SHALL leave Out_D holding the last drained value when EMPTY; that value carries no meaning.

Reset
REQ-023 SHALL, on any Clk edge with Rst=1, set state EMPTY, main=0, skid=0, Out_Valid=0 and In_Ready=1.
REQ-024 SHALL give Rst priority over Flush, accept and drain; words in flight when Rst is asserted mid-operation are discarded.
REQ-025 SHALL resume accepting on the first edge after Rst deasserts.

Configuration
REQ-026 SHALL, with macro PIPE_SKID_FLUSH_EN defined, provide Flush: on an edge with Flush=1, state goes to EMPTY and the entries are unchanged; an accept or drain in that cycle is ignored; Rst still dominates.
REQ-027 SHALL, without PIPE_SKID_FLUSH_EN, omit the Flush port and its logic entirely.

Structure
REQ-028 SHALL place the state enumeration and the default width constant (32) in shared package pipe_pkg.
REQ-029 SHALL use sub-module pipe_entry_reg, a WIDTH-bit register with load enable and synchronous active-high reset to 0, instantiated twice (main and skid).

Verification
REQ-030 SHALL cover: after Rst, In_Valid=1 with In_D=0x12345678 and Out_Ready=1 -> Out_D=0x12345678 and Out_Valid=1 on the next cycle.
REQ-031 SHALL cover: Out_Ready=0, then offer 0xA, 0xB, 0xC -> 0xA and 0xB are accepted, In_Ready=0 after the second accept, and 0xC is held upstream.
REQ-032 SHALL cover: from FULL(0xA,0xB), raise Out_Ready=1 -> outputs 0xA, 0xB, 0xC on consecutive cycles, with In_Ready back to 1 one cycle after the first drain.
REQ-033 SHALL cover: a streaming run of 0x0 to 0xFF with In_Valid=1 and Out_Ready=1 -> 256 words in order at one per cycle, with no In_Ready drop.
REQ-034 SHALL cover: Rst pulse while FULL -> next cycle Out_Valid=0, Out_D=0, In_Ready=1.
REQ-035 SHALL cover, with PIPE_SKID_FLUSH_EN defined: Flush=1 while FULL and In_Valid=1 with 0xD -> next cycle EMPTY, 0xD not captured, Out_Valid=0.
